// File: rtl/prores_dc_coeff_decoder_if.sv
// Handshake bundle between a slice controller / bitstream source and the ProRes DC
// coefficient decoder: slice start, 32-bit bitstream words and decoded DC output.
interface prores_dc_coeff_decoder_if;
  logic               start;
  logic [5:0]         num_blocks;
  logic [31:0]        bs_data;
  logic               bs_valid;
  logic               bs_ready;
  logic signed [19:0] dc_coeff;
  logic [5:0]         dc_index;
  logic               dc_valid;
  logic               dc_ready;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, num_blocks, bs_data, bs_valid, dc_ready,
    input  bs_ready, dc_coeff, dc_index, dc_valid, busy, done, err
  );

  modport slave (
    input  start, num_blocks, bs_data, bs_valid, dc_ready,
    output bs_ready, dc_coeff, dc_index, dc_valid, busy, done, err
  );
endinterface

// File: rtl/prores_dc_coeff_decoder.sv
// Decodes the adaptive Rice/exp-Golomb DC codewords of one ProRes slice from an
// MSB-first 32-bit word stream and rebuilds the signed 20-bit DC values.
module prores_dc_coeff_decoder #(
  parameter int unsigned MAX_PREFIX  = 20,
  parameter logic [7:0]  FIRST_DC_CB = 8'hB8
) (
  input logic                      clk,
  input logic                      reset_n,
  prores_dc_coeff_decoder_if.slave bus
);
  localparam int QW = $clog2(MAX_PREFIX + 2);
  localparam int SW = $clog2(MAX_PREFIX + 8);
  localparam int AW = MAX_PREFIX + 6;
  localparam logic [QW-1:0] QMAX = QW'(MAX_PREFIX);

  typedef enum logic [2:0] {IDLE, PREFIX, SUFFIX, CALC, OUT, FIN} state_t;

  state_t             state;
  state_t             state_nx;
  logic [5:0]         cnt;
  logic [5:0]         nblk;
  logic [5:0]         idx;
  logic signed [19:0] dc_q;
  logic               err_q;
  logic [31:0]        sreg;
  logic [QW-1:0]      q;
  logic [SW-1:0]      rem;
  logic [AW-1:0]      sacc;
  logic [2:0]         prev_cl;
  logic signed [19:0] prev_dc;
  logic               sign;

  logic               rdy;
  logic               bit_in;
  logic               start_acc;
  logic               load;
  logic               consume;
  logic [7:0]         cb;
  logic               q_le_s;
  logic [SW-1:0]      slen_c;
  logic [31:0]        code_c;
  logic signed [19:0] mag;
  logic signed [19:0] dc_nx;
  logic               sign_nx;

  function automatic logic [7:0] cb_lookup(input logic [2:0] k);
    case (k)
      3'd0:       cb_lookup = 8'h04;
      3'd1, 3'd2: cb_lookup = 8'h28;
      3'd3, 3'd4: cb_lookup = 8'h4D;
      default:    cb_lookup = 8'h70;
    endcase
  endfunction

  function automatic logic [2:0] clamp_code(input logic [31:0] c);
    clamp_code = (c > 32'd6) ? 3'd6 : c[2:0];
  endfunction

  assign bit_in    = sreg[31];
  assign start_acc = (state == IDLE) && bus.start;
  assign load      = rdy && bus.bs_valid;
  assign consume   = ((state == PREFIX) || (state == SUFFIX)) && (cnt != 6'd0);

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nx = (bus.num_blocks == 6'd0) ? FIN : PREFIX;
      PREFIX: begin
        rdy = (cnt == 6'd0);
        if (cnt != 6'd0) begin
          if (bit_in)         state_nx = (slen_c == '0) ? CALC : SUFFIX;
          else if (q == QMAX) state_nx = FIN;
        end
      end
      SUFFIX: begin
        rdy = (cnt == 6'd0);
        if ((cnt != 6'd0) && (rem == SW'(1))) state_nx = CALC;
      end
      CALC: state_nx = OUT;
      OUT:  if (bus.dc_ready) state_nx = ((idx + 6'd1) == nblk) ? FIN : PREFIX;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Codebook selection, suffix length and the code/DC reconstruction for CALC.
  always_comb begin
    cb     = (idx == 6'd0) ? FIRST_DC_CB : cb_lookup(prev_cl);
    q_le_s = (q <= QW'(cb[1:0]));
    slen_c = q_le_s ? SW'(cb[7:5])
                    : SW'(q) + SW'(cb[4:2]) - SW'(cb[1:0]) - SW'(1);
    if (q_le_s)
      code_c = (32'(q) << cb[7:5]) + 32'(sacc);
    else
      code_c = ((32'd1 << slen_c) | 32'(sacc)) - (32'd1 << cb[4:2])
             + ((32'(cb[1:0]) + 32'd1) << cb[7:5]);
    // (code+1)>>1 and (code>>1)+(code&1) agree in the low 20 bits, even on wrap.
    mag = signed'(code_c[20:1] + {19'd0, code_c[0]});
    if (idx == 6'd0) begin
      sign_nx = 1'b0;
      dc_nx   = signed'(code_c[20:1] ^ {20{code_c[0]}});
    end else begin
      sign_nx = (code_c == 32'd0) ? 1'b0 : (sign ^ code_c[0]);
      dc_nx   = sign_nx ? (prev_dc - mag) : (prev_dc + mag);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      nblk  <= '0;
      idx   <= '0;
      dc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_acc || (state == FIN)) cnt <= '0;
      else if (load)                   cnt <= 6'd32;
      else if (consume)                cnt <= cnt - 6'd1;
      if (start_acc) begin
        nblk  <= bus.num_blocks;
        idx   <= '0;
        err_q <= 1'b0;
      end
      if ((state == PREFIX) && consume && !bit_in && (q == QMAX)) err_q <= 1'b1;
      if (state == CALC) dc_q <= dc_nx;
      if ((state == OUT) && bus.dc_ready) idx <= idx + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load)         sreg <= bus.bs_data;
    else if (consume) sreg <= {sreg[30:0], 1'b0};

    if (start_acc || ((state == OUT) && bus.dc_ready)) q <= '0;
    else if ((state == PREFIX) && consume && !bit_in)  q <= q + QW'(1);

    if ((state == PREFIX) && consume && bit_in) begin
      rem  <= slen_c;
      sacc <= '0;
    end else if ((state == SUFFIX) && consume) begin
      rem  <= rem - SW'(1);
      sacc <= {sacc[AW-2:0], bit_in};
    end

    if (state == CALC) begin
      prev_dc <= dc_nx;
      sign    <= sign_nx;
      prev_cl <= (idx == 6'd0) ? 3'd5 : clamp_code(code_c);
    end
  end

  assign bus.bs_ready = rdy;
  assign bus.dc_coeff = dc_q;
  assign bus.dc_index = idx;
  assign bus.dc_valid = (state == OUT);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FIN);
  assign bus.err      = err_q;
endmodule

// File: tb/tb_prores_dc_coeff_decoder.sv
// Directed bench for prores_dc_coeff_decoder: table of slices with hand-decoded
// DC values, plus back-pressure, abort-by-reset and empty-slice sequences.
module tb_prores_dc_coeff_decoder;
  typedef struct packed {
    logic [5:0]       nb;
    logic [1:0]       nw;
    logic [1:0][31:0] w;
    logic [1:0]       n_out;
    logic [2:0][19:0] dc;
    logic             err;
    logic             chk_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  vec_t vecs [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prores_dc_coeff_decoder_if bus ();

  prores_dc_coeff_decoder #(.MAX_PREFIX(20), .FIRST_DC_CB(8'hB8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] nb, input logic [1:0] nw,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [1:0] n_out, input logic [19:0] d0,
                              input logic [19:0] d1, input logic [19:0] d2,
                              input logic err, input logic chk_lat);
    vec_t v;
    v.nb = nb; v.nw = nw; v.w[0] = w0; v.w[1] = w1; v.n_out = n_out;
    v.dc[0] = d0; v.dc[1] = d1; v.dc[2] = d2; v.err = err; v.chk_lat = chk_lat;
    return v;
  endfunction

  task automatic run_slice(input string tag, input vec_t v, input int hold);
    int words = 0, outs = 0, rdy_cyc = 0, load_cyc = -1, dv_cyc = -1, held = 0, budget = 0;
    logic [19:0] hold_dc = '0;
    logic [5:0]  hold_idx = '0;
    logic        stable = 1'b1;
    logic        seen_done = 1'b0;
    bus.num_blocks = v.nb;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!seen_done && budget < 400) begin
      bus.bs_valid = (words < int'(v.nw));
      bus.bs_data  = (words == 0) ? v.w[0] : v.w[1];
      if (bus.bs_ready) begin
        rdy_cyc++;
        if (bus.bs_valid) begin
          if (words == 0) load_cyc = cyc;
          words++;
        end
      end
      bus.dc_ready = 1'b1;
      if (bus.dc_valid) begin
        if (dv_cyc < 0) dv_cyc = cyc;
        if (held == 0) begin
          hold_dc  = bus.dc_coeff;
          hold_idx = bus.dc_index;
        end else if (bus.dc_coeff !== hold_dc || bus.dc_index !== hold_idx || bus.bs_ready)
          stable = 1'b0;
        if (held < hold) begin
          bus.dc_ready = 1'b0;
          held++;
        end else begin
          if (outs < 3) begin
            check($sformatf("%s dc%0d", tag, outs), 64'($unsigned(bus.dc_coeff)), 64'(v.dc[outs]));
            check($sformatf("%s idx%0d", tag, outs), 64'(bus.dc_index), 64'(outs));
          end
          outs++;
          held = 0;
        end
      end
      if (bus.done) begin
        seen_done = 1'b1;
        check({tag, " err at done"}, 64'(bus.err), 64'(v.err));
      end
      @(negedge clk);
      budget++;
    end
    bus.bs_valid = 1'b0;
    check({tag, " done seen"}, 64'(seen_done), 64'd1);
    check({tag, " done single pulse/idle"}, 64'({bus.done, bus.busy}), 64'd0);
    check({tag, " dc count"}, 64'(outs), 64'(v.n_out));
    check({tag, " words taken"}, 64'(words), 64'(v.nw));
    check({tag, " bs_ready cycles"}, 64'(rdy_cyc), 64'(v.nw));
    // dc_valid rises on the 7th clock edge after the edge that loads the word.
    if (v.chk_lat) check({tag, " latency"}, 64'(dv_cyc - load_cyc), 64'd8);
    if (hold > 0)  check({tag, " stable while held"}, 64'(stable), 64'd1);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.num_blocks = '0;
    bus.bs_data    = '0;
    bus.bs_valid   = 1'b0;
    bus.dc_ready   = 1'b0;
    #2;
    check("reset outputs", 64'({bus.bs_ready, bus.dc_coeff, bus.dc_index, bus.dc_valid,
                                bus.busy, bus.done, bus.err}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    vecs[0] = mk(6'd2, 2'd1, 32'h82000000, 32'h0, 2'd2, 20'h00000, 20'h00000, 20'h0, 1'b0, 1'b1);
    vecs[1] = mk(6'd3, 2'd1, 32'h86940000, 32'h0, 2'd3, 20'hFFFFF, 20'h00000, 20'hFFFFE, 1'b0, 1'b0);
    // Long block-0 codeword (q=12) puts the word boundary inside block 1's suffix.
    vecs[2] = mk(6'd3, 2'd2, 32'h00080002, 32'h94000000, 2'd3, 20'h0FFF0, 20'h0FFF1, 20'h0FFEF, 1'b0, 1'b0);
    // Largest legal prefix (20 zeros): 25-bit suffix, DC truncated to 20 bits.
    vecs[3] = mk(6'd1, 2'd2, 32'h00000800, 32'h00000000, 2'd1, 20'hFFFF0, 20'h0, 20'h0, 1'b0, 1'b0);
    vecs[4] = mk(6'd1, 2'd1, 32'h00000000, 32'h0, 2'd0, 20'h0, 20'h0, 20'h0, 1'b1, 1'b0);
    vecs[5] = vecs[0];

    for (int i = 0; i < 6; i++) run_slice($sformatf("vec%0d", i), vecs[i], 0);
    run_slice("hold", vecs[1], 10);

    bus.num_blocks = 6'd2;
    bus.start      = 1'b1;
    bus.dc_ready   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort bs_ready", 64'(bus.bs_ready), 64'd1);
    bus.bs_data  = 32'h82000000;
    bus.bs_valid = 1'b1;
    @(negedge clk);
    bus.bs_valid = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(bus.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1 check("abort outputs", 64'({bus.bs_ready, bus.dc_coeff, bus.dc_index, bus.dc_valid,
                                   bus.busy, bus.done, bus.err}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_slice("fresh", vecs[0], 0);

    bus.num_blocks = 6'd0;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("empty done", 64'({bus.done, bus.bs_ready}), 64'd2);
    @(negedge clk);
    check("empty after", 64'({bus.done, bus.busy, bus.bs_ready}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/prores_dc_coeff_decoder.md
Name: prores_dc_coeff_decoder

Overview:
- Entropy decoder for the DC coefficients of one ProRes slice; inverse of the DC entropy encoder.
- Consumes an MSB-first 32-bit word bitstream and decodes one adaptive Rice/exp-Golomb codeword per block.
- Undoes the first-DC signed mapping and the DC differential/sign-toggle prediction.
- Emits signed 20-bit DC values in block order to the dequantiser/IDCT path.

Parameters:
- MAX_PREFIX, 20, largest legal leading-zero count; a larger count is a bitstream error.
- FIRST_DC_CB, 8'hB8, codebook for block 0.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a slice; sampled only in IDLE
- num_blocks  in  6  DC count for the slice, latched on start
- bs_data  in  32  bitstream word; bit 31 is consumed first
- bs_valid  in  1  bs_data valid
- bs_ready  out  1  decoder accepts bs_data this cycle
- dc_coeff  out  20  decoded signed DC value
- dc_index  out  6  block index of dc_coeff
- dc_valid  out  1  dc_coeff valid; held until dc_ready
- dc_ready  in  1  downstream accepts
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse when the slice completes
- err  out  1  sticky prefix-overflow error; cleared by the next start

Behaviour:
- Reset (async, reset_n=0): state IDLE; bit buffer empty; outputs bs_ready, dc_coeff, dc_index, dc_valid, busy, done, err all 0.
- Codebook byte cb fields: R=cb[7:5] (rice order), E=cb[4:2] (exp order), S=cb[1:0] (switch bits).
- Block i>0 uses cb = table[min(prev_code,6)].
  - table = {04,28,28,4D,4D,70,70}.
  - prev_code starts at 5 for block 1.
- Codeword decode:
  - q = count of 0 bits before the first 1; the terminating 1 is consumed.
  - If q<=S: read R bits r; code=(q<<R)+r.
  - Else: read n=q+E-S-1 bits m; V=(1<<n)|m; code=V-(1<<E)+((S+1)<<R).
  - Arithmetic is 32-bit unsigned.
- Block 0: dc = (code>>1) XOR -(code&1); prev_dc=dc; sign=0.
- Block i>0:
  - If code=0, sign=0; else sign ^= -(code&1).
  - prev_dc += (((code+1)>>1) XOR sign) - sign.
  - dc = prev_dc; result truncated to 20 bits (two's complement).
- Bit buffer: a 32-bit shift register plus a 6-bit count.
  - start flushes the buffer; each slice begins word-aligned.
  - bs_ready=1 only when count=0 and state is PREFIX or SUFFIX.
  - Accepting a word (bs_valid&bs_ready) loads the buffer, count=32; no bit is consumed in the load cycle.
  - Leftover bits carry across codewords within the slice and are discarded at done.
- FSM:
  - IDLE: on start, latch num_blocks and clear err and index.
    - num_blocks=0: go to FIN.
    - Otherwise: go to PREFIX.
  - PREFIX: consume 1 bit/cycle when count>0, otherwise stall.
    - 0 bit: q++.
    - 1 bit: go to SUFFIX; go to CALC instead if the suffix length is 0.
    - q reaching MAX_PREFIX+1: set err and go to FIN; no dc_valid for that block.
  - SUFFIX: consume 1 bit/cycle when count>0, MSB first, until the suffix length is read; then CALC.
  - CALC: one cycle; compute code and dc, update prev_dc/sign/prev_code; go to OUT.
  - OUT: dc_valid=1 with dc_coeff and dc_index stable. On dc_ready, index++.
    - If index+1=num_blocks: go to FIN.
    - Otherwise: q=0, go to PREFIX.
  - FIN: done=1 for one cycle; go to IDLE.
- Latency with the buffer filled: q+1 (prefix) + suffix bits + 1 (CALC) cycles to dc_valid. Each empty-buffer event adds at least 1 load cycle.
- start while busy: ignored.
- dc_ready already high when dc_valid rises: transfer in that same cycle.
- Async reset mid-slice: abort immediately, drop partial state, return to IDLE.

Test Plan:
- Reset, then start with num_blocks=2 and word 0x82000000 -> dc 0 (idx0), dc 0 (idx1); done pulses once; exactly 1 word accepted; first dc_valid 7 cycles after the word-load cycle.
- num_blocks=3, word 0x86940000 -> dc -1 (0xFFFFF), 0, -2 (0xFFFFE). Exercises Rice, exp-Golomb (block 2: q=1, suffix "01"), and the sign toggle.
- Same stream as the previous case, but block 1 split across a word boundary (first word 0x86000000 read as 8 valid bits, then a word continuing the stream) -> identical outputs; bs_ready reasserts exactly when count=0.
- dc_ready held low for 10 cycles at each output -> dc_valid, dc_coeff and dc_index stay stable; no bits consumed while held; outputs are unchanged afterwards.
- Word 0x00000000 with num_blocks=1 -> err=1 after 21 zeros; done pulses; no dc_valid. The next start clears err.
- reset_n low mid-SUFFIX -> all outputs 0 immediately. A fresh start with 0x82000000 then decodes correctly; num_blocks=0 -> done one cycle after start, bs_ready never asserted.
